// File: rtl/shared_mem_arbiter_if.sv
// shared_mem_arbiter_if: requester-side request and read-response channels of the shared memory arbiter
interface shared_mem_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_write;
  logic [NUM_REQ-1:0]            req_lock;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            resp_valid;
  logic [DATA_WIDTH-1:0]         resp_rdata;
  modport master (
    output req_valid, req_write, req_lock, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata
  );
  modport slave (
    input  req_valid, req_write, req_lock, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/shared_mem_arbiter.sv
// shared_mem_arbiter: round-robin arbiter with timed lock sharing one registered shared-memory port
module shared_mem_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 4,
  parameter int LOCK_TIMEOUT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  shared_mem_arbiter_if.slave   bus,
  output logic                  mem_read_en,
  output logic                  mem_write_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  lock_timeout
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(LOCK_TIMEOUT);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state;
  logic [IW-1:0] rr_ptr, owner, gnt_idx, cand, tag, rsp_tag;
  logic [CW-1:0] lock_cnt;
  logic gnt_any, rsp_v;
  function automatic logic [IW-1:0] inc(input logic [IW-1:0] i);
    return (i == IW'(NUM_REQ-1)) ? IW'(0) : i + IW'(1);
  endfunction
  // descending scan so the requester closest to rr_ptr is the one left standing
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      cand = IW'((int'(rr_ptr) + k) % NUM_REQ);
      if (bus.req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    if (state == LOCKED) begin
      gnt_any = bus.req_valid[owner];
      gnt_idx = owner;
    end
  end
  assign bus.req_ready  = reset ? (NUM_REQ'(gnt_any) << gnt_idx) : '0;
  assign bus.resp_valid = rsp_v ? (NUM_REQ'(1) << rsp_tag) : '0;
  assign bus.resp_rdata = rsp_v ? mem_read_data : '0;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      owner          <= '0;
      rr_ptr         <= '0;
      lock_cnt       <= '0;
      lock_timeout   <= 1'b0;
      mem_read_en    <= 1'b0;
      mem_write_en   <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      tag            <= '0;
      rsp_v          <= 1'b0;
      rsp_tag        <= '0;
    end else begin
      mem_read_en  <= gnt_any & ~bus.req_write[gnt_idx];
      mem_write_en <= gnt_any & bus.req_write[gnt_idx];
      if (gnt_any) begin
        mem_addr       <= bus.req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        mem_write_data <= bus.req_wdata[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
        tag            <= gnt_idx;
      end
      rsp_v        <= mem_read_en;
      rsp_tag      <= tag;
      lock_timeout <= 1'b0;
      if (state == IDLE) begin
        if (gnt_any) rr_ptr <= inc(gnt_idx);
        if (gnt_any && bus.req_lock[gnt_idx]) begin
          state    <= LOCKED;
          owner    <= gnt_idx;
          lock_cnt <= '0;
        end
      end else if (gnt_any && !bus.req_lock[owner]) begin
        state  <= IDLE;
        rr_ptr <= inc(owner);
      end else if (lock_cnt == CW'(LOCK_TIMEOUT-1)) begin
        state        <= IDLE;
        rr_ptr       <= inc(owner);
        lock_timeout <= 1'b1;
      end else begin
        lock_cnt <= lock_cnt + CW'(1);
      end
    end
  end
endmodule

// File: doc/shared_mem_arbiter.md
Name: shared_mem_arbiter

Overview:
Round-robin arbiter that shares one port of the shared memory between NUM_REQ requesters (cores/threads). Each requester gets a valid/ready request channel and a read-response channel. The arbiter also supports short locked sequences, such as read-modify-write, with a timeout. It sits between the compute cores and one shared_memory port, drives that port's registered command, and routes the 1-cycle-latency read data back to the issuing requester.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, data width
ADDR_WIDTH, 4, memory address width
LOCK_TIMEOUT, 8, max cycles a lock is held before forced release (>=2)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = in reset)
req_valid  in  NUM_REQ  request pending, one bit per requester
req_ready  out  NUM_REQ  one-hot grant; handshake = valid & ready
req_write  in  NUM_REQ  1 = write, 0 = read
req_lock  in  NUM_REQ  enter/hold lock on accept
req_addr  in  NUM_REQ*ADDR_WIDTH  packed, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  in  NUM_REQ*DATA_WIDTH  packed, same layout
resp_valid  out  NUM_REQ  read data valid for requester i, 1-cycle pulse
resp_rdata  out  DATA_WIDTH  read data; meaningful only when a resp_valid bit is high
mem_read_en  out  1  to memory port
mem_write_en  out  1  to memory port
mem_addr  out  ADDR_WIDTH  to memory port
mem_write_data  out  DATA_WIDTH  to memory port
mem_read_data  in  DATA_WIDTH  from memory port; registered, valid the cycle after mem_read_en
lock_timeout  out  1  1-cycle pulse on forced lock release

Behaviour:
- Reset (reset=0, asynchronous):
  - req_ready, resp_valid, mem_read_en, mem_write_en and lock_timeout = 0.
  - mem_addr and mem_write_data = 0.
  - rr_ptr = 0, state = IDLE, lock counter = 0.
  - An in-flight read is dropped and gets no response.
- Grant (combinational from req_valid, state, rr_ptr):
  - IDLE: grant the first requester with req_valid=1, searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - LOCKED(o): grant only o, if req_valid[o]=1; all other requesters wait.
  - At most one req_ready bit is high. req_ready never depends on req_ready being observed. Requesters hold valid and payload until the handshake.
- On an accepted request from requester g in cycle T:
  - In T+1: registered mem_read_en = ~req_write[g] and mem_write_en = req_write[g], with mem_addr and mem_write_data from g. Both enables deassert in T+1 if there was no handshake in T.
  - rr_ptr <= (g+1) mod NUM_REQ, in IDLE only.
  - Reads: a tag register records g. In T+2, resp_valid[g]=1 and resp_rdata = mem_read_data. Read latency is 2 cycles from handshake to response.
  - Writes produce no response. A write accepted in T is visible to a read accepted in T+1 or later.
- Throughput: one transaction per cycle. Back-to-back reads from different requesters return in order, one per cycle.
- State machine:
  - IDLE -> LOCKED(g) when the accepted request has req_lock[g]=1; lock counter cleared.
  - LOCKED(o): the counter increments every cycle.
  - LOCKED(o) -> IDLE when o's accepted request has req_lock=0. That request is still performed. rr_ptr <= o+1.
  - LOCKED(o) -> IDLE when the counter reaches LOCK_TIMEOUT-1 with no releasing handshake. lock_timeout pulses in the next cycle and rr_ptr <= o+1. If a handshake from o with req_lock=1 happens in that same cycle, it is performed and the timeout still applies.
- resp_rdata = 0 when no resp_valid bit is set.
- Unused requesters (req_valid=0 forever) never receive ready or valid.

Test Plan:
- Reset, then memory preloaded [0]=5,[1]=3,[2]=7,[3]=2. Requester 0 reads addr 2 -> req_ready[0] same cycle; mem_read_en/mem_addr=2 at T+1; resp_valid[0]=1, resp_rdata=7 at T+2.
- All 4 requesters hold read valid (addr 0,1,2,3) from reset -> grants in order 0,1,2,3 on consecutive cycles. Responses 5,3,7,2 on resp_valid[0..3] at T+2..T+5. A re-assertion of requester 0 is then granted again, with no starvation.
- Requester 1 writes addr 8=0x2A, then requester 2 reads addr 8 the next cycle -> resp_valid[2] with 0x2A.
- Requester 3 reads addr 0 with lock=1 while requester 0 is valid. Requester 0 stays waiting. Requester 3 then writes addr 0=6 with lock=0 -> requester 0 is granted the following cycle; memory[0]=6.
- Requester 1 locks and then holds req_valid=0 -> lock_timeout pulses after LOCK_TIMEOUT cycles; requester 2 is granted next.
- Reset asserted in the cycle after a read handshake -> no resp_valid afterwards. All outputs are 0 while reset=0. After release, the first grant goes to requester 0.
